// File: rtl/vga_sync_gen_if.sv
// ---------------------------------------------------------------------------
// vga_sync_gen_if
// Bundles the renderer-facing and pin-facing signals of the VGA timing
// generator.
//   rgb_in      [2:0]  colour from the text-overlay renderer, {R,G,B}
//   p_tick             pixel-rate enable, one clk wide
//   pix_x       [9:0]  horizontal counter
//   pix_y       [9:0]  vertical counter
//   video_on           counters are inside the visible area
//   frame_start        one-clk pulse after the counters wrap to (0,0)
//   hsync, vsync       active-low sync pins
//   rgb         [2:0]  colour driven to the DAC pins
// Modports: master = timing generator, slave = renderer / pins side.
// ---------------------------------------------------------------------------
interface vga_sync_gen_if;
    logic [2:0] rgb_in;
    logic       p_tick;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_on;
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb;

    modport master (
        input  rgb_in,
        output p_tick, pix_x, pix_y, video_on, frame_start, hsync, vsync, rgb
    );

    modport slave (
        output rgb_in,
        input  p_tick, pix_x, pix_y, video_on, frame_start, hsync, vsync, rgb
    );
endinterface

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// 640x480 @ 60 Hz VGA timing generator. Divides clk into a pixel enable,
// runs the horizontal/vertical counters, decodes the sync pulses and the
// visible window, and gates the renderer colour onto the RGB pins.
// Ports:
//   clk    system clock (rising edge)
//   reset  synchronous, active-high
//   vga    vga_sync_gen_if.master (rgb_in in; p_tick, pix_x, pix_y,
//          video_on, frame_start, hsync, vsync, rgb out)
// Optional build macro: VGA_RGB_REG_EN -- registers rgb/hsync/vsync on the
// pixel enable, giving them a one-pixel lag relative to pix_x/pix_y.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       pix_x_q, pix_x_d;
    logic [9:0]       pix_y_q, pix_y_d;
    logic             frame_start_q, frame_start_d;

    logic             p_tick;
    logic             h_end;
    logic             v_end;
    logic             video_on;
    logic             hsync_dec;
    logic             vsync_dec;
    logic [2:0]       rgb_dec;

    always_comb begin
        // Gated by reset so that CLK_DIV=1 (div stuck at 0) still idles.
        p_tick = !reset && (div_q == DIV_LAST);
        h_end  = (pix_x_q == 10'(H_TOTAL - 1));
        v_end  = (pix_y_q == 10'(V_TOTAL - 1));

        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
        if (p_tick) begin
            if (h_end) begin
                pix_x_d = '0;
                pix_y_d = v_end ? '0 : pix_y_q + 10'd1;
            end else begin
                pix_x_d = pix_x_q + 10'd1;
            end
        end

        // Registered one edge after the simultaneous H/V wrap.
        frame_start_d = p_tick && h_end && v_end;

        video_on  = (pix_x_q < 10'(H_DISPLAY)) && (pix_y_q < 10'(V_DISPLAY));
        hsync_dec = !((pix_x_q >= 10'(HS_START)) && (pix_x_q <= 10'(HS_END)));
        vsync_dec = !((pix_y_q >= 10'(VS_START)) && (pix_y_q <= 10'(VS_END)));
        rgb_dec   = video_on ? vga.rgb_in : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_RGB_REG_EN
    // Pin-side outputs sampled once per pixel so the DAC and sync pins
    // switch together, one pixel behind the counters.
    logic [2:0] rgb_q, rgb_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (p_tick) begin
            rgb_d   = rgb_dec;
            hsync_d = hsync_dec;
            vsync_d = vsync_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q   <= 3'b000;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vga.rgb   = rgb_q;
    assign vga.hsync = hsync_q;
    assign vga.vsync = vsync_q;
`else
    assign vga.rgb   = rgb_dec;
    assign vga.hsync = hsync_dec;
    assign vga.vsync = vsync_dec;
`endif

    assign vga.p_tick      = p_tick;
    assign vga.pix_x       = pix_x_q;
    assign vga.pix_y       = pix_y_q;
    assign vga.video_on    = video_on;
    assign vga.frame_start = frame_start_q;

endmodule
